// File: rtl/spi_slave_rx_sampler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_rx_sampler_pkg
//  Description : Shared types and constants for the SPI slave receive sampler.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_slave_rx_sampler_pkg;

    typedef enum logic [1:0] {
        ST_RESYNC = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int BIT_CNT_W = 16;

    // Modes 0 and 3 sample MOSI on the rising SCLK edge, modes 1 and 2 on the falling one.
    function automatic logic mode_samples_rising(input logic [1:0] mode);
        case (mode)
            MODE1, MODE2: return 1'b0;
            default:      return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_rx_sampler_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_rx_sampler_if
//  Description : Raw SPI pins plus the frame/bit strobes towards the packer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_rx_sampler_if;

    logic spi_sclk;
    logic spi_cs_n;
    logic spi_mosi;
    logic start;
    logic finish;
    logic rx_data;
    logic rx_valid;
    logic frame_err;

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi,
        input  start, finish, rx_data, rx_valid, frame_err
    );

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi,
        output start, finish, rx_data, rx_valid, frame_err
    );

endinterface
`default_nettype wire

// File: rtl/spi_slave_rx_sampler_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_rx_sampler_pin_sync
//  Description : Synchroniser, optional glitch filter and edge detector for one
//                asynchronous pin. Filter enabled by SPI_RX_GLITCH_FILTER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx_sampler_pin_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VAL   = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_pin,
    output logic      o_sync,
    output logic      o_level,
    output logic      o_rise,
    output logic      o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_level;
    logic                   w_sync_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    assign w_sync_last = r_sync[SYNC_STAGES-1];

`ifdef SPI_RX_GLITCH_FILTER_EN
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= RESET_VAL;
        end else begin
            r_prev <= w_sync_last;
        end
    end

    // A new level is accepted once it has been seen on two consecutive clocks;
    // otherwise the last accepted level (the history flop) is held.
    assign w_level = (w_sync_last == r_prev) ? w_sync_last : r_hist;
    assign o_sync  = r_prev;
`else
    assign w_level = w_sync_last;
    assign o_sync  = w_sync_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= RESET_VAL;
        end else begin
            r_hist <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_hist;
    assign o_fall  = ~w_level & r_hist;

endmodule
`default_nettype wire

// File: rtl/spi_slave_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_rx_sampler
//  Description : SPI slave RX front end: oversamples SCLK/CS_N/MOSI and emits
//                frame markers, qualified bits and a frame-length error flag.
//                Optional glitch filter: SPI_RX_GLITCH_FILTER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx_sampler
    import spi_slave_rx_sampler_pkg::*;
#(
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic              clock,
    input  wire logic              rst,
    spi_slave_rx_sampler_if.slave  spi
);

    localparam logic [1:0] c_ST_RESYNC   = ST_RESYNC;
    localparam logic [1:0] c_ST_IDLE     = ST_IDLE;
    localparam logic [1:0] c_ST_ACTIVE   = ST_ACTIVE;
    localparam logic [1:0] c_MODE        = {CPOL, CPHA};
    localparam logic       c_SAMPLE_RISE = mode_samples_rising(c_MODE);
    // Cycles to let the reset presets drain out of the synchronisers (filter included)
    localparam logic [7:0] c_FLUSH       = 8'(SYNC_STAGES + 2);

    logic w_sclk_sync, w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_sync,   w_cs_level,   w_cs_rise,   w_cs_fall;
    logic w_mosi_sync, w_mosi_level, w_mosi_rise, w_mosi_fall;
    logic w_sample;
    logic w_unused;

    logic [1:0]           r_state;
    logic [7:0]           r_flush;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic                 r_start;
    logic                 r_finish;
    logic                 r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;

    spi_slave_rx_sampler_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (CPOL)
    ) u_sclk_sync (
        .clk     (clock),
        .rst     (rst),
        .i_pin   (spi.spi_sclk),
        .o_sync  (w_sclk_sync),
        .o_level (w_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_slave_rx_sampler_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk     (clock),
        .rst     (rst),
        .i_pin   (spi.spi_cs_n),
        .o_sync  (w_cs_sync),
        .o_level (w_cs_level),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_slave_rx_sampler_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_mosi_sync (
        .clk     (clock),
        .rst     (rst),
        .i_pin   (spi.spi_mosi),
        .o_sync  (w_mosi_sync),
        .o_level (w_mosi_level),
        .o_rise  (w_mosi_rise),
        .o_fall  (w_mosi_fall)
    );

    assign w_unused = &{1'b0, w_sclk_sync, w_sclk_level, w_cs_sync,
                        w_mosi_level, w_mosi_rise, w_mosi_fall};

    assign w_sample = c_SAMPLE_RISE ? w_sclk_rise : w_sclk_fall;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state     <= c_ST_RESYNC;
            r_flush     <= '0;
            r_bit_cnt   <= '0;
            r_start     <= 1'b0;
            r_finish    <= 1'b0;
            r_rx_data   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_start     <= 1'b0;
            r_finish    <= 1'b0;
            r_rx_data   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                c_ST_RESYNC: begin
                    // A frame that was live at reset release is skipped: only a
                    // genuinely deasserted chip select re-arms the receiver.
                    if (r_flush != c_FLUSH) begin
                        r_flush <= r_flush + 8'd1;
                    end else if (w_cs_level) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_start   <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= c_ST_ACTIVE;
                    end
                end
                c_ST_ACTIVE: begin
                    if (w_cs_rise) begin
                        r_finish    <= 1'b1;
                        r_frame_err <= (r_bit_cnt[2:0] != 3'd0);
                        r_state     <= c_ST_IDLE;
                    end else if (w_sample) begin
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= w_mosi_sync;
                        if (r_bit_cnt != {BIT_CNT_W{1'b1}}) begin
                            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_RESYNC;
                end
            endcase
        end
    end

    assign spi.start     = r_start;
    assign spi.finish    = r_finish;
    assign spi.rx_data   = r_rx_data;
    assign spi.rx_valid  = r_rx_valid;
    assign spi.frame_err = r_frame_err;

endmodule
`default_nettype wire
